// File: rtl/nr_mem_pkg.sv
// nr_mem_pkg: shared state encoding and overflow flag bit indices for the register bank
package nr_mem_pkg;
  typedef enum logic {SWEEP, RUN} state_t;
  localparam int OVF_POS = 0;
  localparam int OVF_NEG = 1;
endpackage

// File: rtl/nr_clear_sweeper.sv
// nr_clear_sweeper: SWEEP/RUN controller, one clear address per cycle; ports clk, clr (async), wipe -> busy, sweep_adr, sweep_we
module nr_clear_sweeper
  import nr_mem_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              wipe,
  output logic              busy,
  output logic [ADDR_W-1:0] sweep_adr,
  output logic              sweep_we
);
  state_t          state;
  logic [ADDR_W:0] cnt;
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= SWEEP;
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (wipe) begin
      state <= SWEEP;
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (state == SWEEP) begin
      cnt <= cnt + 1'b1;
      if (cnt[ADDR_W-1:0] == '1) begin
        state <= RUN;
        busy  <= 1'b0;
      end
    end
  end
  // the extra counter bit keeps a finished count from aliasing onto address 0
  assign sweep_adr = cnt[ADDR_W-1:0];
  assign sweep_we  = (state == SWEEP) && !cnt[ADDR_W];
endmodule

// File: rtl/nr_param_register_bank.sv
// nr_param_register_bank: DATA_W x 2**ADDR_W bank, N_RD registered read ports with write-first bypass, sticky overflow flags, clear sweep; ports clk, clr (async), wipe, can_wrt, can_rd, adr_in, in0, adr_out, ovrflw -> rb_out, busy
module nr_param_register_bank
  import nr_mem_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int N_RD      = 3,
  parameter int FLAG_ADDR = 1
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     wipe,
  input  logic                     can_wrt,
  input  logic                     can_rd,
  input  logic [ADDR_W-1:0]        adr_in,
  input  logic [DATA_W-1:0]        in0,
  input  logic [N_RD*ADDR_W-1:0]   adr_out,
  input  logic [1:0]               ovrflw,
  output logic [N_RD*DATA_W-1:0]   rb_out,
  output logic                     busy
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd [N_RD];
  logic [DATA_W-1:0] ovf_mask;
  logic [DATA_W-1:0] wdat;
  logic [ADDR_W-1:0] sweep_adr;
  logic              sweep_we;
  nr_clear_sweeper #(.ADDR_W(ADDR_W)) u_sweep (
    .clk       (clk),
    .clr       (clr),
    .wipe      (wipe),
    .busy      (busy),
    .sweep_adr (sweep_adr),
    .sweep_we  (sweep_we)
  );
  assign ovf_mask = DATA_W'({ovrflw[OVF_NEG], ovrflw[OVF_POS]});
  // a user write to the flag entry still absorbs this cycle's overflow pulse
  assign wdat = in0 | ((adr_in == ADDR_W'(FLAG_ADDR)) ? ovf_mask : '0);
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (sweep_we) begin
        if (sweep_adr == ADDR_W'(i)) mem[i] <= '0;
      end else if (!wipe) begin
        if (can_wrt && adr_in == ADDR_W'(i)) mem[i] <= wdat;
        else if (i == FLAG_ADDR) mem[i] <= mem[i] | ovf_mask;
      end
    end
  end
  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra    = adr_out[k*ADDR_W +: ADDR_W];
    assign rd[k] = (can_wrt && ra == adr_in) ? wdat : mem[ra];
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) rb_out <= '0;
    else if (sweep_we || wipe) rb_out <= '0;
    else if (can_rd) for (int k = 0; k < N_RD; k++) rb_out[k*DATA_W +: DATA_W] <= rd[k];
  end
endmodule

// File: tb/tb_nr_param_register_bank.sv
// tb_nr_param_register_bank: directed checks of sweep, read/write, bypass, flags, wipe and async clear
module tb_nr_param_register_bank;
  logic        clk = 0;
  logic        clr, wipe, can_wrt, can_rd;
  logic [3:0]  adr_in;
  logic [7:0]  in0;
  logic [11:0] adr_out;
  logic [1:0]  ovrflw;
  logic [23:0] rb_out;
  logic        busy;
  logic        clr2, wipe2, can_wrt2, can_rd2;
  logic [4:0]  adr_in2;
  logic [7:0]  in02;
  logic [19:0] adr_out2;
  logic [1:0]  ovrflw2;
  logic [31:0] rb_out2;
  logic        busy2;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n;
  always #5 clk = ~clk;
  nr_param_register_bank dut (
    .clk(clk), .clr(clr), .wipe(wipe), .can_wrt(can_wrt), .can_rd(can_rd),
    .adr_in(adr_in), .in0(in0), .adr_out(adr_out), .ovrflw(ovrflw),
    .rb_out(rb_out), .busy(busy)
  );
  nr_param_register_bank #(.ADDR_W(5), .N_RD(4)) dut2 (
    .clk(clk), .clr(clr2), .wipe(wipe2), .can_wrt(can_wrt2), .can_rd(can_rd2),
    .adr_in(adr_in2), .in0(in02), .adr_out(adr_out2), .ovrflw(ovrflw2),
    .rb_out(rb_out2), .busy(busy2)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 100) begin
      check("sweep_rb_zero", rb_out, 0);
      tick();
      cnt++;
    end
  endtask
  task automatic read_all_zero(input string tag);
    for (int a = 0; a < 16; a++) begin
      adr_out = {3{4'(a)}};
      can_rd  = 1;
      tick();
      check(tag, rb_out, 0);
    end
    can_rd = 0;
  endtask
  task automatic read1(input logic [3:0] a, input logic [7:0] exp, input string tag);
    adr_out = {3{a}};
    can_rd  = 1;
    tick();
    check(tag, rb_out[7:0], exp);
    can_rd = 0;
  endtask
  initial begin
    clr = 1; wipe = 0; can_wrt = 0; can_rd = 0; adr_in = 0; in0 = 0; adr_out = 0; ovrflw = 0;
    clr2 = 1; wipe2 = 0; can_wrt2 = 0; can_rd2 = 0; adr_in2 = 0; in02 = 0; adr_out2 = 0; ovrflw2 = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1);
    check("rst_rb", rb_out, 0);
    clr = 0;
    count_busy(n);
    check("sweep_len", n, 16);
    read_all_zero("post_clr_read");
    can_wrt = 1; adr_in = 3; in0 = 8'hA5;
    tick();
    can_wrt = 0; adr_out = {4'd3, 4'd3, 4'd0}; can_rd = 1;
    tick();
    check("write_read", rb_out, {8'hA5, 8'hA5, 8'h00});
    can_wrt = 1; adr_in = 5; in0 = 8'h3C; adr_out = {4'd0, 4'd5, 4'd3};
    tick();
    check("bypass", rb_out, {8'h00, 8'h3C, 8'hA5});
    can_wrt = 0; can_rd = 0; adr_out = {4'd5, 4'd5, 4'd5};
    tick();
    check("hold", rb_out, {8'h00, 8'h3C, 8'hA5});
    read1(5, 8'h3C, "bypass_stored");
    ovrflw = 2'b01;
    tick();
    ovrflw = 2'b10;
    tick();
    ovrflw = 2'b00;
    read1(1, 8'h03, "flags_sticky");
    can_wrt = 1; adr_in = 1; in0 = 8'h80; ovrflw = 2'b01;
    tick();
    can_wrt = 0; ovrflw = 2'b00;
    read1(1, 8'h81, "flag_write_or");
    can_wrt = 1; adr_in = 1; in0 = 8'h40; ovrflw = 2'b10; adr_out = {4'd3, 4'd0, 4'd1}; can_rd = 1;
    tick();
    can_wrt = 0; ovrflw = 2'b00; can_rd = 0;
    check("flag_bypass", rb_out, {8'hA5, 8'h00, 8'h42});
    for (int a = 0; a < 16; a++) begin
      can_wrt = 1; adr_in = 4'(a); in0 = 8'hFF;
      tick();
    end
    can_wrt = 0;
    read1(9, 8'hFF, "fill_ff");
    wipe = 1; can_wrt = 1; adr_in = 2; in0 = 8'h11; can_rd = 1; adr_out = {4'd2, 4'd2, 4'd2};
    tick();
    wipe = 0; can_wrt = 0; can_rd = 0;
    check("wipe_busy", busy, 1);
    check("wipe_rb", rb_out, 0);
    count_busy(n);
    check("wipe_len", n, 16);
    read_all_zero("post_wipe_read");
    can_wrt = 1; adr_in = 12; in0 = 8'h5A;
    tick();
    can_wrt = 0;
    wipe = 1;
    tick();
    wipe = 0;
    repeat (7) tick();
    check("mid_sweep_busy", busy, 1);
    #2 clr = 1;
    #1 check("clr_busy", busy, 1);
    @(negedge clk);
    clr = 0;
    count_busy(n);
    check("clr_restart_len", n, 16);
    read1(12, 8'h00, "clr_cleared");
    clr2 = 0;
    n = 0;
    while (busy2 && n < 100) begin
      tick();
      n++;
    end
    check("sweep2_len", n, 32);
    can_wrt2 = 1;
    adr_in2 = 0;  in02 = 8'h11; tick();
    adr_in2 = 9;  in02 = 8'h22; tick();
    adr_in2 = 17; in02 = 8'h33; tick();
    adr_in2 = 31; in02 = 8'h44; tick();
    can_wrt2 = 0; can_rd2 = 1; adr_out2 = {5'd31, 5'd17, 5'd9, 5'd0};
    tick();
    check("four_port_read", rb_out2, {8'h44, 8'h33, 8'h22, 8'h11});
    can_wrt2 = 1; adr_in2 = 20; in02 = 8'h77; adr_out2 = {5'd20, 5'd20, 5'd31, 5'd0};
    tick();
    check("four_port_bypass", rb_out2, {8'h77, 8'h77, 8'h44, 8'h11});
    can_wrt2 = 0; can_rd2 = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
